// File: rtl/nco_sched_pkg.sv
// Shared widths and defaults for the multi-channel NCO scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nco_sched_pkg;
    localparam int PHASE_W        = 32;
    localparam int Z_W            = 18;
    localparam int IQ_W           = 16;
    localparam int NCH_DEF        = 4;
    localparam int CORDIC_LAT_DEF = 18;
    localparam int CH_W_DEF       = $clog2(NCH_DEF);

    // Channel index for the default channel count
    typedef logic [CH_W_DEF-1:0] ch_idx_t;
endpackage

// File: rtl/nco_sched_rr_arbiter.sv
// Round-robin arbiter: picks one pending channel per cycle, searching from the one after the last grant.
// Latency: combinational grant from i_pend; the pointer updates on the grant edge.
// Backpressure: none; an unserved request simply stays pending for a later cycle.
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NCH-1:0]  i_pend,
    output logic [NCH-1:0]  o_gnt,
    output logic [CH_W-1:0] o_idx,
    output logic            o_vld
);
    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_cand;

    // Scan channels starting at r_ptr and take the first pending one
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        for (int i = 0; i < NCH; i++) begin
            w_cand = CH_W'((int'(r_ptr) + i) % NCH);
            if (!o_vld && i_pend[w_cand]) begin
                o_vld         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    // Next search begins just after the channel granted this cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (o_vld) begin
            r_ptr <= (o_idx == CH_W'(NCH - 1)) ? '0 : o_idx + 1'b1;
        end
    end
endmodule

// File: rtl/nco_sched.sv
// Time-shares one external cossin core among NCH phase accumulators; NCO_SCHED_OVF_EN enables sticky overflow flags.
// Latency: result appears on out_* exactly CORDIC_LAT+2 cycles after the grant cycle, one result per cycle.
// Backpressure: none; a request hitting an already-pending channel is dropped (and flagged when enabled).
module nco_sched
    import nco_sched_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int CORDIC_LAT = CORDIC_LAT_DEF,
    localparam int CH_W      = $clog2(NCH)
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         ch_en,
    input  logic                   cfg_we,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [PHASE_W-1:0]     cfg_ftw,
    input  logic                   cfg_phase_clr,
    output logic [Z_W-1:0]         cs_z,
    input  logic signed [IQ_W-1:0] cs_x,
    input  logic signed [IQ_W-1:0] cs_y,
    output logic                   out_valid,
    output logic [CH_W-1:0]        out_ch,
    output logic signed [IQ_W-1:0] out_i,
    output logic signed [IQ_W-1:0] out_q,
    output logic [NCH-1:0]         ovf,
    input  logic                   ovf_clr
);
    logic [NCH-1:0]         r_pend;
    logic [PHASE_W-1:0]     r_acc [NCH];
    logic [PHASE_W-1:0]     r_ftw [NCH];
    logic [Z_W-1:0]         r_cs_z;
    logic                   r_z_vld;
    logic [CH_W-1:0]        r_z_ch;
    logic [CORDIC_LAT-1:0]  r_tag_vld;
    logic [CH_W-1:0]        r_tag_ch [CORDIC_LAT];
    logic                   r_out_vld;
    logic [CH_W-1:0]        r_out_ch;
    logic signed [IQ_W-1:0] r_out_i;
    logic signed [IQ_W-1:0] r_out_q;

    logic [NCH-1:0]         w_gnt;
    logic [CH_W-1:0]        w_gnt_idx;
    logic                   w_gnt_vld;
    logic [NCH-1:0]         w_drop;

    rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_pend (r_pend),
        .o_gnt  (w_gnt),
        .o_idx  (w_gnt_idx),
        .o_vld  (w_gnt_vld)
    );

    // A request on a still-pending, ungranted, enabled channel is lost
    assign w_drop = ch_en & req & r_pend & ~w_gnt;

    // Pending bits: grant clears, same-cycle request re-arms, disabled channels stay clear
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= ch_en & ((r_pend & ~w_gnt) | req);
        end
    end

    // FTW writes and accumulator steps; a grant adds the pre-write FTW and a phase clear overrides the step
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c] <= '0;
                r_ftw[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_we && cfg_ch == CH_W'(c)) begin
                    r_ftw[c] <= cfg_ftw;
                end
                if (cfg_we && cfg_phase_clr && cfg_ch == CH_W'(c)) begin
                    r_acc[c] <= '0;
                end else if (w_gnt[c]) begin
                    r_acc[c] <= r_acc[c] + r_ftw[c];
                end
            end
        end
    end

    // Phase to the core is the pre-update accumulator top bits; it holds between grants
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cs_z  <= '0;
            r_z_vld <= 1'b0;
            r_z_ch  <= '0;
        end else begin
            r_z_vld <= w_gnt_vld;
            r_z_ch  <= w_gnt_idx;
            if (w_gnt_vld) begin
                r_cs_z <= r_acc[w_gnt_idx][PHASE_W-1 -: Z_W];
            end
        end
    end

    // Tag line follows cs_z through the core so each result is labelled with its channel
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tag_vld <= '0;
            for (int k = 0; k < CORDIC_LAT; k++) begin
                r_tag_ch[k] <= '0;
            end
        end else begin
            r_tag_vld <= {r_tag_vld[CORDIC_LAT-2:0], r_z_vld};
            r_tag_ch[0] <= r_z_ch;
            for (int k = 1; k < CORDIC_LAT; k++) begin
                r_tag_ch[k] <= r_tag_ch[k-1];
            end
        end
    end

    // Register the core result together with its tag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_out_vld <= 1'b0;
            r_out_ch  <= '0;
            r_out_i   <= '0;
            r_out_q   <= '0;
        end else begin
            r_out_vld <= r_tag_vld[CORDIC_LAT-1];
            if (r_tag_vld[CORDIC_LAT-1]) begin
                r_out_ch <= r_tag_ch[CORDIC_LAT-1];
                r_out_i  <= cs_x;
                r_out_q  <= cs_y;
            end
        end
    end

`ifdef NCO_SCHED_OVF_EN
    logic [NCH-1:0] r_ovf;

    // Sticky drop flags; a new drop beats a simultaneous clear
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~{NCH{ovf_clr}}) | w_drop;
        end
    end

    assign ovf = r_ovf;
`else
    logic [NCH:0] w_unused_ovf;
    assign w_unused_ovf = {ovf_clr, w_drop};
    assign ovf          = '0;
`endif

    assign cs_z      = r_cs_z;
    assign out_valid = r_out_vld;
    assign out_ch    = r_out_ch;
    assign out_i     = r_out_i;
    assign out_q     = r_out_q;
endmodule

// File: tb/tb_nco_sched.sv
// Directed bench for nco_sched with a behavioural cossin stand-in.
// Latency: stand-in core delays z by CORDIC_LAT cycles.
// Backpressure: n/a.
module tb_nco_sched;
    import nco_sched_pkg::*;

    localparam int NCH = 4;
    localparam int LAT = 18;
`ifdef NCO_SCHED_OVF_EN
    localparam logic [3:0] OVF_EXP = 4'b0100;
`else
    localparam logic [3:0] OVF_EXP = 4'b0000;
`endif

    logic                   sys_clk = 1'b0;
    logic                   sys_rst = 1'b1;
    logic [NCH-1:0]         req = '0;
    logic [NCH-1:0]         ch_en = '1;
    logic                   cfg_we = 1'b0;
    ch_idx_t                cfg_ch = '0;
    logic [31:0]            cfg_ftw = '0;
    logic                   cfg_phase_clr = 1'b0;
    logic [17:0]            cs_z;
    logic signed [15:0]     cs_x;
    logic signed [15:0]     cs_y;
    logic                   out_valid;
    ch_idx_t                out_ch;
    logic signed [15:0]     out_i;
    logic signed [15:0]     out_q;
    logic [NCH-1:0]         ovf;
    logic                   ovf_clr = 1'b0;

    int checks   = 0;
    int failures = 0;
    int vld_cnt  = 0;

    nco_sched #(.NCH(NCH), .CORDIC_LAT(LAT)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .req           (req),
        .ch_en         (ch_en),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_ftw       (cfg_ftw),
        .cfg_phase_clr (cfg_phase_clr),
        .cs_z          (cs_z),
        .cs_x          (cs_x),
        .cs_y          (cs_y),
        .out_valid     (out_valid),
        .out_ch        (out_ch),
        .out_i         (out_i),
        .out_q         (out_q),
        .ovf           (ovf),
        .ovf_clr       (ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // cossin stand-in: x = z[17:2], y = z[15:0] ^ 16'hA5A5, LAT cycles after z
    logic [17:0] zp [LAT];
    always @(posedge sys_clk) begin
        zp[0] <= cs_z;
        for (int k = 1; k < LAT; k++) zp[k] <= zp[k-1];
    end
    assign cs_x = signed'(zp[LAT-1][17:2]);
    assign cs_y = signed'(zp[LAT-1][15:0] ^ 16'hA5A5);

    typedef struct {
        logic [3:0]  req;
        logic        cfg_we;
        logic [1:0]  cfg_ch;
        logic [31:0] cfg_ftw;
        logic        chk_z;
        logic [17:0] exp_z;
        logic        exp_vld;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
        if (out_valid) vld_cnt++;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        req = '0; cfg_we = 1'b0; cfg_phase_clr = 1'b0; ovf_clr = 1'b0;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [31:0] ftw, input logic clr);
        cfg_we = 1'b1; cfg_ch = ch; cfg_ftw = ftw; cfg_phase_clr = clr;
        step();
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
    endtask

    // One request pulse on channel mask m, then one idle cycle in which the grant lands on cs_z
    task automatic pulse_and_grant(input logic [3:0] m);
        req = m;
        step();
        req = '0;
        step();
    endtask

    initial begin
        int n;

        // Single channel 0 stream: three grants, cs_z holds afterwards
        for (int r = 0; r < 25; r++) begin
            tbl[r] = '{req: 4'h0, cfg_we: 1'b0, cfg_ch: 2'd0, cfg_ftw: 32'h0, chk_z: 1'b0,
                       exp_z: 18'h0, exp_vld: 1'b0, exp_i: 16'h0, exp_q: 16'h0};
        end
        tbl[0].cfg_we = 1'b1; tbl[0].cfg_ftw = 32'h0080_0000; tbl[0].chk_z = 1'b1; tbl[0].exp_z = 18'd0;
        tbl[1].req = 4'h1; tbl[1].chk_z = 1'b1; tbl[1].exp_z = 18'd0;
        tbl[2].req = 4'h1; tbl[2].chk_z = 1'b1; tbl[2].exp_z = 18'd0;
        tbl[3].req = 4'h1; tbl[3].chk_z = 1'b1; tbl[3].exp_z = 18'd512;
        tbl[4].chk_z = 1'b1; tbl[4].exp_z = 18'd1024;
        tbl[5].chk_z = 1'b1; tbl[5].exp_z = 18'd1024;
        tbl[6].chk_z = 1'b1; tbl[6].exp_z = 18'd1024;
        tbl[21].exp_vld = 1'b1; tbl[21].exp_i = 16'd0;   tbl[21].exp_q = 16'hA5A5;
        tbl[22].exp_vld = 1'b1; tbl[22].exp_i = 16'd128; tbl[22].exp_q = 16'hA7A5;
        tbl[23].exp_vld = 1'b1; tbl[23].exp_i = 16'd256; tbl[23].exp_q = 16'hA1A5;

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_cs_z", {14'd0, cs_z}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
        chk("rst_out_i", {16'd0, out_i}, 32'd0);
        chk("rst_out_q", {16'd0, out_q}, 32'd0);
        chk("rst_ovf", {28'd0, ovf}, 32'd0);
        sys_rst = 1'b0;

        for (int r = 0; r < 25; r++) begin
            req = tbl[r].req; cfg_we = tbl[r].cfg_we; cfg_ch = tbl[r].cfg_ch; cfg_ftw = tbl[r].cfg_ftw;
            step();
            if (tbl[r].chk_z) chk($sformatf("tbl%0d_cs_z", r), {14'd0, cs_z}, {14'd0, tbl[r].exp_z});
            chk($sformatf("tbl%0d_out_valid", r), {31'd0, out_valid}, {31'd0, tbl[r].exp_vld});
            if (tbl[r].exp_vld) begin
                chk($sformatf("tbl%0d_out_ch", r), {30'd0, out_ch}, 32'd0);
                chk($sformatf("tbl%0d_out_i", r), {16'd0, out_i}, {16'd0, tbl[r].exp_i});
                chk($sformatf("tbl%0d_out_q", r), {16'd0, out_q}, {16'd0, tbl[r].exp_q});
            end
        end
        req = '0; cfg_we = 1'b0;

        // All four channels at once: grant order 0..3, results back to back
        do_reset();
        req = 4'hF;
        step();
        req = '0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("all_first_latency", n, 20);
        chk("all_ch0", {30'd0, out_ch}, 32'd0);
        for (int c = 1; c < 4; c++) begin
            step();
            chk($sformatf("all_vld%0d", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("all_ch%0d", c), {30'd0, out_ch}, c);
        end
        step();
        chk("all_done", {31'd0, out_valid}, 32'd0);

        // Accumulator wrap on channel 1
        cfg_write(2'd1, 32'hFFFF_FF00, 1'b1);
        pulse_and_grant(4'h2);
        chk("wrap_pre", {14'd0, cs_z}, 32'd0);
        cfg_write(2'd1, 32'h0000_0200, 1'b0);
        pulse_and_grant(4'h2);
        chk("wrap_top", {14'd0, cs_z}, 32'h3FFFF);
        pulse_and_grant(4'h2);
        chk("wrap_zero", {14'd0, cs_z}, 32'd0);

        // Overflow: second req[2] arrives while ch1 holds the grant
        do_reset();
        vld_cnt = 0;
        req = 4'b0011; step();
        req = 4'b0100; step();
        req = 4'b0100; step();
        chk("ovf_set", {28'd0, ovf}, {28'd0, OVF_EXP});
        req = '0; step();
        chk("ovf_sticky", {28'd0, ovf}, {28'd0, OVF_EXP});
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_cleared", {28'd0, ovf}, 32'd0);
        repeat (25) step();
        chk("ovf_out_cnt", vld_cnt, 3);

        // Config write with phase clear colliding with a grant on channel 3
        cfg_write(2'd3, 32'h0040_0000, 1'b1);
        pulse_and_grant(4'h8);
        chk("col_pre", {14'd0, cs_z}, 32'd0);
        req = 4'h8; step(); req = '0;
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_ftw = 32'h0100_0000; cfg_phase_clr = 1'b1;
        step();
        cfg_we = 1'b0; cfg_phase_clr = 1'b0;
        chk("col_old_acc", {14'd0, cs_z}, 32'd256);
        pulse_and_grant(4'h8);
        chk("col_cleared", {14'd0, cs_z}, 32'd0);
        pulse_and_grant(4'h8);
        chk("col_new_ftw", {14'd0, cs_z}, 32'd1024);

        // Reset 5 cycles after a grant flushes the in-flight result
        req = 4'h1; step(); req = '0;
        repeat (5) step();
        sys_rst = 1'b1;
        step(); step();
        sys_rst = 1'b0;
        vld_cnt = 0;
        repeat (30) step();
        chk("rst_flush", vld_cnt, 0);

        // Disabled channel ignores requests; re-enabled it is served once
        ch_en = 4'b1011; req = 4'b0100;
        repeat (5) step();
        req = '0;
        repeat (25) step();
        chk("en_gate", vld_cnt, 0);
        ch_en = 4'hF;
        vld_cnt = 0;
        req = 4'b0100; step(); req = '0;
        repeat (25) step();
        chk("en_served", vld_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
